neg2c_serial: RTL and testbench



---
 rtl/neg2c_serial_if.sv | 25 ++
 rtl/neg2c_serial.sv | 117 +++++++++++
 tb/tb_neg2c_serial.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/neg2c_serial_if.sv
// Operand/result handshake bundle for the serial two's-complement negator.
interface neg2c_serial_if #(
  parameter int unsigned WIDTH = 25
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  // Producer/consumer side driving the unit
  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  // The negation unit itself
  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/neg2c_serial.sv
// Multi-cycle two's-complement pass/negate/abs unit, CHUNK bits per cycle
// through a registered carry. Optional feature macro: NEG2C_SERIAL_OVF_EN
// (most-negative-operand overflow flag; out_ovf tied 0 when undefined).
module neg2c_serial #(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned CHUNK = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  neg2c_serial_if.slave bus
);

  localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned SHW    = $clog2(NCHUNK * CHUNK) + 1;
  localparam logic [WIDTH-1:0] CHUNK_ONES = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_last;
  logic             w_neg;

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_res;
  logic             r_neg;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;

  logic [SHW-1:0]   w_shift;
  logic [CHUNK-1:0] w_src;
  logic [CHUNK-1:0] w_opnd;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_last   = (r_idx == IDXW'(NCHUNK - 1));
  assign w_accept = w_in_ready & bus.in_valid;
  assign w_neg    = (bus.in_mode == 2'b01) | ((bus.in_mode == 2'b10) & bus.in_data[WIDTH-1]);

  // One chunk of (neg ? ~d : d) + carry; bits past WIDTH-1 fall off the shift
  assign w_shift   = SHW'(r_idx) * SHW'(CHUNK);
  assign w_src     = CHUNK'(r_data >> w_shift);
  assign w_opnd    = r_neg ? ~w_src : w_src;
  assign w_sum     = {1'b0, w_opnd} + (CHUNK + 1)'(r_carry);
  assign w_mask    = CHUNK_ONES << w_shift;
  assign w_res_nxt = (r_res & ~w_mask) | ((WIDTH'(w_sum[CHUNK-1:0]) << w_shift) & w_mask);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and ready; DONE can hand straight back to RUN on a consumed result
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_in_ready = bus.out_ready;
        if (bus.out_ready) w_state_nxt = bus.in_valid ? RUN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture and chunk-serial result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_res   <= '0;
      r_neg   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_data  <= bus.in_data;
      r_neg   <= w_neg;
      r_carry <= w_neg;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_res   <= w_res_nxt;
      r_carry <= w_sum[CHUNK];
      r_idx   <= r_idx + IDXW'(1);
    end
  end

`ifdef NEG2C_SERIAL_OVF_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH - 1){1'b0}}};
  logic r_ovf;

  // Overflow known at capture: only negating the most-negative value wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ovf <= 1'b0;
    else if (w_accept) r_ovf <= w_neg & (bus.in_data == MOST_NEG);
  end

  assign bus.out_ovf = r_ovf;
`else
  assign bus.out_ovf = 1'b0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_data  = r_res;

endmodule

// File: tb/tb_neg2c_serial.sv
// Randomised self-checking bench: two instances (25/8 and 10/4) against an
// arithmetic modulo-2^W reference model.
module tb_neg2c_serial;

  localparam int unsigned WA = 25;
  localparam int unsigned CA = 8;
  localparam int unsigned NA = 4;
  localparam int unsigned WB = 10;
  localparam int unsigned CB = 4;
  localparam int unsigned NB = 3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  neg2c_serial_if #(.WIDTH(WA)) ifa ();
  neg2c_serial_if #(.WIDTH(WB)) ifb ();

  neg2c_serial #(.WIDTH(WA), .CHUNK(CA)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  neg2c_serial #(.WIDTH(WB), .CHUNK(CB)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic on the operand value
  task automatic model(input logic [63:0] d, input logic [1:0] m, input int unsigned w,
                       output logic [63:0] rd, output logic ro);
    logic [63:0] modv;
    logic [63:0] x;
    bit          neg;
    modv = 64'd1 << w;
    x    = d % modv;
    neg  = (m == 2'd1) || ((m == 2'd2) && (x >= (modv >> 1)));
    rd   = neg ? ((modv - x) % modv) : x;
    ro   = 1'b0;
`ifdef NEG2C_SERIAL_OVF_EN
    ro   = neg && (x == (modv >> 1));
`endif
  endtask

  task automatic drive(input int u, input logic v, input logic [63:0] d, input logic [1:0] m);
    if (u == 0) begin
      ifa.in_valid = v; ifa.in_data = WA'(d); ifa.in_mode = m;
    end else begin
      ifb.in_valid = v; ifb.in_data = WB'(d); ifb.in_mode = m;
    end
  endtask

  task automatic set_ordy(input int u, input logic v);
    if (u == 0) ifa.out_ready = v;
    else        ifb.out_ready = v;
  endtask

  function automatic logic rdy(input int u);
    return (u == 0) ? ifa.in_ready : ifb.in_ready;
  endfunction

  function automatic logic ovld(input int u);
    return (u == 0) ? ifa.out_valid : ifb.out_valid;
  endfunction

  function automatic logic [63:0] odata(input int u);
    return (u == 0) ? 64'(ifa.out_data) : 64'(ifb.out_data);
  endfunction

  function automatic logic oovf(input int u);
    return (u == 0) ? ifa.out_ovf : ifb.out_ovf;
  endfunction

  task automatic wait_valid(input int u, output int cyc);
    cyc = 0;
    while (!ovld(u) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Full transaction through IDLE: accept, scramble inputs, check latency/result, consume
  task automatic run_op(input int u, input logic [63:0] data, input logic [1:0] mode, input string tag);
    int          cyc;
    int unsigned w;
    int unsigned nch;
    logic [63:0] exp_d;
    logic        exp_o;
    w   = (u == 0) ? WA : WB;
    nch = (u == 0) ? NA : NB;
    model(data, mode, w, exp_d, exp_o);
    cyc = 0;
    while (!rdy(u) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_rdy"}, 64'(rdy(u)), 64'd1);
    drive(u, 1'b1, data, mode);
    @(posedge clk); #1;
    drive(u, 1'b0, {$urandom, $urandom}, 2'($urandom));
    wait_valid(u, cyc);
    check({tag, "_lat"}, 64'(cyc), 64'(nch));
    check({tag, "_data"}, odata(u), exp_d);
    check({tag, "_ovf"}, 64'(oovf(u)), 64'(exp_o));
    set_ordy(u, 1'b1);
    @(posedge clk); #1;
    set_ordy(u, 1'b0);
    check({tag, "_vld_drop"}, 64'(ovld(u)), 64'd0);
  endtask

  function automatic logic [63:0] pick_data(input int unsigned w);
    logic [63:0] modv;
    modv = 64'd1 << w;
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return modv >> 1;
      2:       return modv - 1;
      3:       return 64'd1;
      default: return {$urandom, $urandom} % modv;
    endcase
  endfunction

  initial begin
    int          cyc;
    int          bad;
    logic [63:0] exp_d;
    logic        exp_o;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(0, 1'b0, 64'd0, 2'd0);
    drive(1, 1'b0, 64'd0, 2'd0);
    set_ordy(0, 1'b0);
    set_ordy(1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(ifa.out_valid), 64'd0);
    check("rst_out_data", 64'(ifa.out_data), 64'd0);
    check("rst_out_ovf", 64'(ifa.out_ovf), 64'd0);
    check("rst_in_ready", 64'(ifa.in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 64'h0000001, 2'd1, "neg_one");
    run_op(0, 64'h1FFFF00, 2'd2, "abs_neg256");
    run_op(0, 64'h0000100, 2'd2, "abs_pos256");
    run_op(0, 64'h1000000, 2'd1, "neg_mostneg");
    run_op(0, 64'h1234567, 2'd0, "pass");
    run_op(0, 64'h1234567, 2'd3, "mode3_pass");

    // Backpressure: hold the result, then accept a new operand in the consume cycle
    model(64'h1000000, 2'd1, WA, exp_d, exp_o);
    drive(0, 1'b1, 64'h1000000, 2'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 64'h0155555, 2'd2);
    wait_valid(0, cyc);
    check("bp_valid", 64'(ifa.out_valid), 64'd1);
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ifa.out_data !== WA'(exp_d) || ifa.out_ovf !== exp_o ||
          ifa.in_ready !== 1'b0 || ifa.out_valid !== 1'b1) bad++;
    end
    check("bp_hold_cycles_bad", 64'(bad), 64'd0);
    check("bp_hold_data", 64'(ifa.out_data), exp_d);
    ifa.out_ready = 1'b1;
    drive(0, 1'b1, 64'h0000003, 2'd1);
    #1;
    check("bp_same_cycle_rdy", 64'(ifa.in_ready), 64'd1);
    @(posedge clk); #1;
    ifa.out_ready = 1'b0;
    drive(0, 1'b0, 64'h0000077, 2'd0);
    check("bp_vld_drop", 64'(ifa.out_valid), 64'd0);
    wait_valid(0, cyc);
    check("bp_next_lat", 64'(cyc), 64'(NA));
    check("bp_next_data", 64'(ifa.out_data), 64'h1FFFFFD);
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    ifa.out_ready = 1'b0;

    // Reset two cycles into RUN discards the operand
    drive(0, 1'b1, 64'h0000055, 2'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 64'd0, 2'd0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(ifa.out_valid), 64'd0);
    check("midrst_out_data", 64'(ifa.out_data), 64'd0);
    check("midrst_out_ovf", 64'(ifa.out_ovf), 64'd0);
    check("midrst_in_ready", 64'(ifa.in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ifa.out_valid !== 1'b0) bad++;
    end
    check("midrst_stale_valid", 64'(bad), 64'd0);
    run_op(0, 64'h0ABCDEF, 2'd0, "post_rst_pass");

    // Narrow instance: partial top chunk
    run_op(1, 64'h000, 2'd1, "b_neg_zero");
    run_op(1, 64'h0FF, 2'd1, "b_neg_0ff");
    run_op(1, 64'h200, 2'd1, "b_neg_mostneg");

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      run_op(0, pick_data(WA), 2'($urandom_range(0, 3)), "rand_a");
    end
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      run_op(1, pick_data(WB), 2'($urandom_range(0, 3)), "rand_b");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
